// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage slice.
//  - ALU_WIDTH / ALU_RD_W : default datapath and destination-tag widths
//  - FLAG_* indices       : bit positions inside the 4-bit {N,Z,C,V} flag word
//  - alu_result_t         : one buffered result entry {s, rd, flags}
//  - skid_state_e         : occupancy of the 2-entry skid buffer
//  - derive_flags()       : NZCV derivation from an adder result
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_RD_W  = 5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] s;
        logic [ALU_RD_W-1:0]  rd;
        logic [3:0]           flags;
    } alu_result_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,  // nothing held
        SKID_ONE   = 2'd1,  // head register valid, skid register empty
        SKID_FULL  = 2'd2   // head and skid registers both valid
    } skid_state_e;

    // C is the raw adder carry: for subtraction C=1 means "no borrow".
    function automatic logic [3:0] derive_flags(input logic [ALU_WIDTH-1:0] s,
                                                input logic                 carry,
                                                input logic                 overflow);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = s[ALU_WIDTH-1];
        f[FLAG_Z] = (s == '0);
        f[FLAG_C] = carry;
        f[FLAG_V] = overflow;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bus between the adder, the result stage and the writeback consumer.
//  in_*  : adder -> stage (valid/ready, result, carry, overflow, tag, flag write)
//  out_* : stage -> consumer (valid/ready, result, tag, flags)
//  modport slave  : the result stage
//  modport master : the surrounding environment (adder + consumer)
interface alu_result_stage_if #(
    parameter int WIDTH = 64,
    parameter int RD_W  = 5
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic             in_carry;
    logic             in_overflow;
    logic [RD_W-1:0]  in_rd;
    logic             in_flag_we;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic [RD_W-1:0]  out_rd;
    logic [3:0]       out_flags;

    modport slave (
        input  in_valid, in_s, in_carry, in_overflow, in_rd, in_flag_we,
        output in_ready,
        output out_valid, out_s, out_rd, out_flags,
        input  out_ready
    );

    modport master (
        output in_valid, in_s, in_carry, in_overflow, in_rd, in_flag_we,
        input  in_ready,
        input  out_valid, out_s, out_rd, out_flags,
        output out_ready
    );

endinterface

// File: rtl/alu_skid_buf.sv
// 2-entry skid buffer over a packed entry type.
//  clk, rst   : clock, asynchronous active-high reset
//  in_valid   : upstream entry presented
//  in_ready   : registered; low only while both entries are occupied
//  in_data    : upstream entry
//  out_valid  : head entry valid
//  out_ready  : consumer takes head entry
//  out_data   : head entry, held stable while out_valid & !out_ready
// The head register always feeds out_data directly; the skid register only
// catches an entry that arrives while the head is stalled, and is promoted to
// the head on the next drain. Entries leave in strict arrival order.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter type T = alu_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_e state_q, state_d;
    T            main_q, skid_q;
    logic        accept, drain;
    logic        load_main, load_skid, promote_skid;

    assign in_ready  = (state_q != SKID_FULL);
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        promote_skid = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    // Head leaves and is replaced on the same edge.
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = SKID_FULL;
                end else if (drain) begin
                    state_d   = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so no new entry can arrive.
                if (out_ready) begin
                    promote_skid = 1'b1;
                    state_d      = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (promote_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage directly downstream of add_sub_64bit.
//  clk, rst    : clock, asynchronous active-high reset
//  bus         : alu_result_stage_if.slave (in_* from adder, out_* to writeback)
//  flags_q     : architectural {N,Z,C,V}, updated in issue order on flag writes
//  ovf_sticky  : set by any accepted flag-writing overflow op
//  sticky_clr  : clears ovf_sticky and ovf_cnt (a same-cycle overflow wins)
//  ovf_cnt     : saturating count of accepted flag-writing overflow ops
// Flags are derived at accept time and travel with the entry through the
// skid buffer, so flags_q never waits on the consumer.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int RD_W  = ALU_RD_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_result_stage_if.slave bus,
    output logic [3:0]       flags_q,
    output logic             ovf_sticky,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    alu_result_t in_entry;
    alu_result_t out_entry;
    logic        accept;
    logic        ovf_evt;

    always_comb begin
        in_entry       = '0;
        in_entry.s     = bus.in_s;
        in_entry.rd    = bus.in_rd;
        in_entry.flags = derive_flags(bus.in_s, bus.in_carry, bus.in_overflow);
    end

    alu_skid_buf #(
        .T (alu_result_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_entry)
    );

    assign bus.out_s     = out_entry.s;
    assign bus.out_rd    = out_entry.rd;
    assign bus.out_flags = out_entry.flags;

    assign accept  = bus.in_valid & bus.in_ready;
    assign ovf_evt = accept & bus.in_flag_we & bus.in_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (accept && bus.in_flag_we) begin
            flags_q <= in_entry.flags;
        end
    end

    // An overflow in the same cycle as a clear counts as the first event
    // after the clear rather than being swallowed by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (ovf_evt) begin
            ovf_sticky <= 1'b1;
            if (sticky_clr) begin
                ovf_cnt <= CNT_W'(1);
            end else if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end else if (sticky_clr) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                rst;
    logic [3:0]          flags_q;
    logic                ovf_sticky;
    logic                sticky_clr;
    logic [TB_CNT_W-1:0] ovf_cnt;

    int vectors;
    int miscompares;

    alu_result_stage_if #(.WIDTH(64), .RD_W(5)) bus ();

    alu_result_stage #(
        .WIDTH (64),
        .RD_W  (5),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flags_q    (flags_q),
        .ovf_sticky (ovf_sticky),
        .sticky_clr (sticky_clr),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] s, input logic c, input logic v,
                         input logic [4:0] rd, input logic we);
        bus.in_valid    = 1'b1;
        bus.in_s        = s;
        bus.in_carry    = c;
        bus.in_overflow = v;
        bus.in_rd       = rd;
        bus.in_flag_we  = we;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        vectors++; if (bus.out_s !== 64'd0) begin miscompares++; $display("FAIL reset_out_s got %h exp 0", bus.out_s); end
        vectors++; if (bus.out_rd !== 5'd0) begin miscompares++; $display("FAIL reset_out_rd got %h exp 0", bus.out_rd); end
        vectors++; if (bus.out_flags !== 4'b0000) begin miscompares++; $display("FAIL reset_out_flags got %b exp 0000", bus.out_flags); end
        vectors++; if (flags_q !== 4'b0000) begin miscompares++; $display("FAIL reset_flags_q got %b exp 0000", flags_q); end
        vectors++; if (ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky got %b exp 0", ovf_sticky); end
        vectors++; if (ovf_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", ovf_cnt); end
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        drive(64'd5, 1'b0, 1'b0, 5'd3, 1'b1);
        step();
        idle();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid got %b exp 1", bus.out_valid); end
        vectors++; if (bus.out_s !== 64'd5) begin miscompares++; $display("FAIL add_out_s got %h exp 5", bus.out_s); end
        vectors++; if (bus.out_rd !== 5'd3) begin miscompares++; $display("FAIL add_out_rd got %0d exp 3", bus.out_rd); end
        vectors++; if (bus.out_flags !== 4'b0000) begin miscompares++; $display("FAIL add_out_flags got %b exp 0000", bus.out_flags); end
        vectors++; if (flags_q !== 4'b0000) begin miscompares++; $display("FAIL add_flags_q got %b exp 0000", flags_q); end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd4, 1'b1);
        step();
        idle();
        vectors++; if (bus.out_s !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL ovf_out_s got %h exp 8000000000000000", bus.out_s); end
        vectors++; if (bus.out_flags !== 4'b1001) begin miscompares++; $display("FAIL ovf_out_flags got %b exp 1001", bus.out_flags); end
        vectors++; if (flags_q !== 4'b1001) begin miscompares++; $display("FAIL ovf_flags_q got %b exp 1001", flags_q); end
        vectors++; if (ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", ovf_sticky); end
        vectors++; if (ovf_cnt !== 4'd1) begin miscompares++; $display("FAIL ovf_cnt got %0d exp 1", ovf_cnt); end
        step();
    endtask

    task automatic test_sub();
        drive(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        vectors++; if (bus.out_flags !== 4'b1000) begin miscompares++; $display("FAIL sub_neg_flags got %b exp 1000", bus.out_flags); end
        vectors++; if (flags_q !== 4'b1000) begin miscompares++; $display("FAIL sub_neg_flags_q got %b exp 1000", flags_q); end
        drive(64'd2, 1'b1, 1'b0, 5'd6, 1'b1);
        step();
        vectors++; if (bus.out_s !== 64'd2) begin miscompares++; $display("FAIL sub_pos_s got %h exp 2", bus.out_s); end
        vectors++; if (bus.out_flags !== 4'b0010) begin miscompares++; $display("FAIL sub_pos_flags got %b exp 0010", bus.out_flags); end
        vectors++; if (flags_q !== 4'b0010) begin miscompares++; $display("FAIL sub_pos_flags_q got %b exp 0010", flags_q); end
        drive(64'd0, 1'b1, 1'b0, 5'd7, 1'b1);
        step();
        vectors++; if (bus.out_flags !== 4'b0110) begin miscompares++; $display("FAIL sub_zero_flags got %b exp 0110", bus.out_flags); end
        vectors++; if (flags_q !== 4'b0110) begin miscompares++; $display("FAIL sub_zero_flags_q got %b exp 0110", flags_q); end
        // Overflow without flag write: entry flags show it, architectural state does not.
        drive(64'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        step();
        idle();
        vectors++; if (bus.out_flags !== 4'b0101) begin miscompares++; $display("FAIL nowe_flags got %b exp 0101", bus.out_flags); end
        vectors++; if (flags_q !== 4'b0110) begin miscompares++; $display("FAIL nowe_flags_q got %b exp 0110", flags_q); end
        vectors++; if (ovf_cnt !== 4'd1) begin miscompares++; $display("FAIL nowe_cnt got %0d exp 1", ovf_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(64'd1, 1'b0, 1'b0, 5'd1, 1'b0);
        step();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one got %b exp 1", bus.in_ready); end
        drive(64'd2, 1'b0, 1'b0, 5'd2, 1'b0);
        step();
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full got %b exp 0", bus.in_ready); end
        drive(64'd3, 1'b0, 1'b0, 5'd3, 1'b0);
        step();
        step();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_valid got %b exp 1", bus.out_valid); end
        vectors++; if (bus.out_s !== 64'd1) begin miscompares++; $display("FAIL b2b_stall_s got %h exp 1", bus.out_s); end
        vectors++; if (bus.out_rd !== 5'd1) begin miscompares++; $display("FAIL b2b_stall_rd got %0d exp 1", bus.out_rd); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_ready got %b exp 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        vectors++; if (bus.out_s !== 64'd2) begin miscompares++; $display("FAIL b2b_drain2_s got %h exp 2", bus.out_s); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_drain2_ready got %b exp 1", bus.in_ready); end
        step();
        idle();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_drain3_valid got %b exp 1", bus.out_valid); end
        vectors++; if (bus.out_s !== 64'd3) begin miscompares++; $display("FAIL b2b_drain3_s got %h exp 3", bus.out_s); end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_sticky_clr();
        bus.out_ready = 1'b1;
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd9, 1'b1);
        repeat (4) step();
        idle();
        vectors++; if (ovf_cnt !== 4'd5) begin miscompares++; $display("FAIL clr_pre_cnt got %0d exp 5", ovf_cnt); end
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd9, 1'b1);
        sticky_clr = 1'b1;
        step();
        idle();
        vectors++; if (ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL clr_set_sticky got %b exp 1", ovf_sticky); end
        vectors++; if (ovf_cnt !== 4'd1) begin miscompares++; $display("FAIL clr_set_cnt got %0d exp 1", ovf_cnt); end
        step();
        sticky_clr = 1'b0;
        vectors++; if (ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_only_sticky got %b exp 0", ovf_sticky); end
        vectors++; if (ovf_cnt !== 4'd0) begin miscompares++; $display("FAIL clr_only_cnt got %0d exp 0", ovf_cnt); end
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b1;
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd11, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 14) begin
                vectors++; if (ovf_cnt !== 4'd14) begin miscompares++; $display("FAIL sat_14 got %0d exp 14", ovf_cnt); end
            end
            if (i == 15) begin
                vectors++; if (ovf_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_15 got %0d exp 15", ovf_cnt); end
            end
        end
        idle();
        vectors++; if (ovf_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_hold got %0d exp 15", ovf_cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd12, 1'b1);
        step();
        drive(64'h8000_0000_0000_0001, 1'b0, 1'b1, 5'd13, 1'b1);
        step();
        idle();
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_full got %b exp 0", bus.in_ready); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready got %b exp 1", bus.in_ready); end
        vectors++; if (flags_q !== 4'b0000) begin miscompares++; $display("FAIL rmid_flags_q got %b exp 0000", flags_q); end
        vectors++; if (ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL rmid_sticky got %b exp 0", ovf_sticky); end
        vectors++; if (ovf_cnt !== 4'd0) begin miscompares++; $display("FAIL rmid_cnt got %0d exp 0", ovf_cnt); end
        vectors++; if (bus.out_s !== 64'd0) begin miscompares++; $display("FAIL rmid_out_s got %h exp 0", bus.out_s); end
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_no_ghost got %b exp 0", bus.out_valid); end
        drive(64'd5, 1'b0, 1'b0, 5'd14, 1'b1);
        step();
        idle();
        vectors++; if (bus.out_s !== 64'd5) begin miscompares++; $display("FAIL rmid_recover_s got %h exp 5", bus.out_s); end
        vectors++; if (bus.out_rd !== 5'd14) begin miscompares++; $display("FAIL rmid_recover_rd got %0d exp 14", bus.out_rd); end
        step();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        sticky_clr      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_s        = '0;
        bus.in_carry    = 1'b0;
        bus.in_overflow = 1'b0;
        bus.in_rd       = '0;
        bus.in_flag_we  = 1'b0;
        bus.out_ready   = 1'b0;

        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_sticky_clr();
        test_saturate();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
